// File: rtl/dm_jtag_dtm.sv
`default_nettype none
// ============================================================================
//  Module   : dm_jtag_dtm
//  Purpose  : JTAG Debug Transport Module. Oversamples the JTAG pins in the
//             clk domain and turns DMI scans into single DMI transactions.
//  Revision : 1.0  initial release
// ============================================================================
module dm_jtag_dtm #(
    parameter logic [31:0] IDCODE      = 32'h1000_0563,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic        dmi_valid,
    input  logic        dmi_ready,
    output logic        dmi_write,
    output logic [8:2]  dmi_addr,
    output logic [31:0] dmi_wdata,
    input  logic [31:0] dmi_rdata
);

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UP_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UP_IR
    } tap_state_t;

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic                   tck_prev;
    logic                   tck_s;
    logic                   tms_s;
    logic                   tdi_s;
    logic                   rise;
    logic                   fall;

    tap_state_t  tap;
    tap_state_t  tap_next;
    logic [4:0]  ir;
    logic [4:0]  ir_shift;
    logic [40:0] dr_shift;
    logic [31:0] last_rdata;
    logic [1:0]  sticky;
    logic        pending;
    logic        discard;
    logic        handshake;
    logic        pending_eff;
    logic [31:0] dtmcs_capture;
    logic [1:0]  dmi_status;
    logic [1:0]  upd_op;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_prev <= tck_s;
        end
    end

    assign tck_s = tck_sync[SYNC_STAGES-1];
    assign tms_s = tms_sync[SYNC_STAGES-1];
    assign tdi_s = tdi_sync[SYNC_STAGES-1];
    assign rise  = tck_s & ~tck_prev;
    assign fall  = ~tck_s & tck_prev;

    // A handshake in this clk retires the request before any scan event sees it.
    assign handshake     = dmi_valid & dmi_ready;
    assign pending_eff   = pending & ~handshake;
    assign dtmcs_capture = {17'd0, 3'd1, sticky, 6'd7, 4'd1};
    assign dmi_status    = ((sticky != 2'd0) || pending_eff) ? 2'b11 : 2'b00;
    assign upd_op        = dr_shift[1:0];

    always_comb begin
        tap_next = tap;
        case (tap)
            TLR:    tap_next = tms_s ? TLR    : RTI;
            RTI:    tap_next = tms_s ? SEL_DR : RTI;
            SEL_DR: tap_next = tms_s ? SEL_IR : CAP_DR;
            CAP_DR: tap_next = tms_s ? EX1_DR : SH_DR;
            SH_DR:  tap_next = tms_s ? EX1_DR : SH_DR;
            EX1_DR: tap_next = tms_s ? UP_DR  : PA_DR;
            PA_DR:  tap_next = tms_s ? EX2_DR : PA_DR;
            EX2_DR: tap_next = tms_s ? UP_DR  : SH_DR;
            UP_DR:  tap_next = tms_s ? SEL_DR : RTI;
            SEL_IR: tap_next = tms_s ? TLR    : CAP_IR;
            CAP_IR: tap_next = tms_s ? EX1_IR : SH_IR;
            SH_IR:  tap_next = tms_s ? EX1_IR : SH_IR;
            EX1_IR: tap_next = tms_s ? UP_IR  : PA_IR;
            PA_IR:  tap_next = tms_s ? EX2_IR : PA_IR;
            EX2_IR: tap_next = tms_s ? UP_IR  : SH_IR;
            UP_IR:  tap_next = tms_s ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tap        <= TLR;
            ir         <= IR_IDCODE;
            ir_shift   <= 5'd0;
            dr_shift   <= 41'd0;
            last_rdata <= 32'd0;
            sticky     <= 2'd0;
            pending    <= 1'b0;
            discard    <= 1'b0;
            tdo        <= 1'b0;
            dmi_valid  <= 1'b0;
            dmi_write  <= 1'b0;
            dmi_addr   <= 7'd0;
            dmi_wdata  <= 32'd0;
        end else begin
            if (handshake) begin
                dmi_valid <= 1'b0;
                pending   <= 1'b0;
                discard   <= 1'b0;
                if (!dmi_write && !discard) begin
                    last_rdata <= dmi_rdata;
                end
            end

            if (rise) begin
                tap <= tap_next;
                if (tap_next == TLR) begin
                    ir <= IR_IDCODE;
                end
                case (tap)
                    CAP_IR: ir_shift <= 5'b00001;
                    SH_IR:  ir_shift <= {tdi_s, ir_shift[4:1]};
                    CAP_DR: begin
                        case (ir)
                            IR_IDCODE: dr_shift <= {9'd0, IDCODE};
                            IR_DTMCS:  dr_shift <= {9'd0, dtmcs_capture};
                            IR_DMI: begin
                                dr_shift <= {dmi_addr, last_rdata, dmi_status};
                                if (pending_eff) begin
                                    sticky <= 2'b11;
                                end
                            end
                            default:   dr_shift <= 41'd0;
                        endcase
                    end
                    SH_DR: begin
                        case (ir)
                            IR_IDCODE, IR_DTMCS: dr_shift <= {9'd0, tdi_s, dr_shift[31:1]};
                            IR_DMI:              dr_shift <= {tdi_s, dr_shift[40:1]};
                            default:             dr_shift <= {40'd0, tdi_s};
                        endcase
                    end
                    default: ;
                endcase
            end

            if (fall) begin
                if (tap == SH_DR) begin
                    tdo <= dr_shift[0];
                end else if (tap == SH_IR) begin
                    tdo <= ir_shift[0];
                end else begin
                    tdo <= 1'b0;
                end

                if (tap == UP_IR) begin
                    ir <= ir_shift;
                end

                if (tap == UP_DR) begin
                    if (ir == IR_DTMCS) begin
                        if (dr_shift[17]) begin
                            sticky  <= 2'd0;
                            discard <= 1'b1;
                        end else if (dr_shift[16]) begin
                            sticky <= 2'd0;
                        end
                    end else if (ir == IR_DMI && (upd_op == OP_READ || upd_op == OP_WRITE)) begin
                        // A busy or sticky-error DTM drops the request rather than queueing it.
                        if (!pending_eff && sticky == 2'd0) begin
                            dmi_addr  <= dr_shift[40:34];
                            dmi_wdata <= dr_shift[33:2];
                            dmi_write <= (upd_op == OP_WRITE);
                            dmi_valid <= 1'b1;
                            pending   <= 1'b1;
                        end else begin
                            sticky <= 2'b11;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
